// File: rtl/ysyx_23060077_ifu.sv
// Instruction fetch unit: one outstanding imem request, response forwarded straight to IF/ID,
// one-entry hold buffer for downstream stalls, in-flight fetches killed on EX redirect.
module ysyx_23060077_ifu #(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           DATA_W   = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = 32'h3000_0000
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              if_wen,
  output logic              if_flush,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                kill_q, kill_d;
  logic [ADDR_W-1:0]   kill_tgt_q, kill_tgt_d;
  logic [ADDR_W-1:0]   hold_pc_q, hold_pc_d;
  logic [DATA_W-1:0]   hold_inst_q, hold_inst_d;

  logic [ADDR_W-1:0]   tgt;
  logic                deliver_w, deliver_h;

  assign tgt = redirect_pc & ~ADDR_W'(3);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    kill_tgt_d  = kill_tgt_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = tgt;
      end
      S_REQ: begin
        // The address already on the bus stays put; its response is dropped later.
        if (redirect_valid) begin
          kill_d     = 1'b1;
          kill_tgt_d = tgt;
        end
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (redirect_valid)   pc_d = tgt;
          else if (kill_q)      pc_d = kill_tgt_q;
          else if (!stall)      pc_d = pc_q + ADDR_W'(4);
          else begin
            hold_pc_d   = pc_q;
            hold_inst_d = imem_rsp_data;
            state_d     = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d     = 1'b1;
          kill_tgt_d = tgt;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d        = tgt;
          hold_pc_d   = '0;
          hold_inst_d = '0;
          state_d     = S_REQ;
        end else if (!stall) begin
          pc_d    = hold_pc_q + ADDR_W'(4);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      kill_tgt_q  <= '0;
      hold_pc_q   <= '0;
      hold_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      kill_tgt_q  <= kill_tgt_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  // Every output is gated by reset so nothing leaks while reset is held.
  assign imem_req_valid = (state_q == S_REQ) && !reset;
  assign imem_req_addr  = imem_req_valid ? pc_q : '0;
  assign if_flush       = redirect_valid && !reset;

  assign deliver_w = (state_q == S_WAIT) && imem_rsp_valid && !kill_q && !stall
                     && !redirect_valid && !reset;
  assign deliver_h = (state_q == S_HOLD) && !stall && !redirect_valid && !reset;

  assign if_wen  = deliver_w || deliver_h;
  assign if_pc   = deliver_w ? pc_q : (deliver_h ? hold_pc_q : '0);
  assign if_inst = deliver_w ? imem_rsp_data : (deliver_h ? hold_inst_q : '0);

endmodule

// File: doc/ysyx_23060077_ifu.md
# ysyx_23060077_ifu

Instruction fetch unit for the in-order pipeline. Holds the PC, issues one instruction-memory request at a time over a valid/ready request channel, and accepts the matching response. It drives the write-enable, flush and data inputs of the IF/ID pipeline register directly downstream. It absorbs downstream stalls with a one-entry hold buffer and discards in-flight fetches on a redirect from EX.

## Interface
- RESET_PC, 32'h3000_0000, PC of the first fetch after reset
- ADDR_W, 32, address and PC width
- DATA_W, 32, instruction width

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_req_addr  out  ADDR_W  fetch address, word aligned
- imem_rsp_valid  in  1  response valid, one response per accepted request, in order
- imem_rsp_data  in  DATA_W  fetched instruction
- redirect_valid  in  1  branch, jump or trap redirect from EX, single-cycle pulse
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] are ignored and forced to 0
- stall  in  1  IF/ID register must hold this cycle
- if_wen  out  1  load IF/ID register this cycle
- if_flush  out  1  clear IF/ID register this cycle
- if_pc  out  ADDR_W  PC of the presented instruction; 0 when if_wen=0
- if_inst  out  DATA_W  presented instruction; 0 when if_wen=0

## Operation
- **Registered state:**
  - FSM state: IDLE, REQ, WAIT or HOLD.
  - pc.
  - kill flag and kill_target.
  - hold buffer: hold_inst and hold_pc.
- **Reset:** state=IDLE, pc=RESET_PC, kill=0, buffer cleared. All outputs are 0 while reset is asserted.
- **IDLE:** outputs idle. Moves to REQ on the next clock unconditionally.
- **REQ:** imem_req_valid=1 and imem_req_addr=pc.
  - addr and valid stay stable until the handshake (valid&ready).
  - On handshake the FSM moves to WAIT.
  - stall has no effect in REQ.
- **WAIT:** waits for imem_rsp_valid.
  - Response with kill=1: the response is discarded. pc=kill_target, kill=0, next state REQ.
  - Response with kill=0 and stall=0: if_wen=1, if_pc=pc, if_inst=imem_rsp_data, all combinational in the same cycle. pc=pc+4, next state REQ.
  - Response with kill=0 and stall=1: capture hold_pc=pc and hold_inst=imem_rsp_data, next state HOLD.
- **HOLD:** if_wen=0 while stall=1. When stall=0: if_wen=1 with hold_pc and hold_inst, pc=hold_pc+4, next state REQ.
- **Redirect** (redirect_valid=1):
  - if_flush=1 combinationally in the same cycle.
  - if_wen is forced to 0 in that cycle, regardless of state.
  - REQ, with or without a handshake that cycle: kill=1, kill_target=redirect_pc, then
    - with handshake: go to WAIT and discard that response.
    - without handshake: stay in REQ, keep the current addr until accepted, then discard its response in WAIT.
  - WAIT without a response: kill=1, kill_target=redirect_pc.
  - WAIT with a response in the same cycle: the response is discarded. pc=redirect_pc, kill=0, next state REQ.
  - HOLD: buffer dropped, pc=redirect_pc, next state REQ.
  - IDLE: pc=redirect_pc.
  - Redirect while kill=1: kill_target is overwritten, so the last redirect wins.
- **Arithmetic:** pc+4 is modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0.
- **Stray responses:** imem_rsp_valid outside WAIT is ignored.
- **Outstanding requests:** at most 1.

## Timing
- **Reset deassert:** first imem_req_valid appears 1 cycle after reset deasserts (IDLE→REQ).
- **Throughput:** zero-latency memory gives handshake in cycle n, response and if_wen in cycle n+1, next request in cycle n+2. That is 1 instruction per 2 cycles.
- **Response path:** response to if_wen is combinational, 0 cycles.
- **HOLD release:** if_wen asserts in the first cycle with stall=0.
- **Redirect to new fetch:**
  - No fetch in flight: the new target appears on imem_req_addr 1 cycle after redirect_valid.
  - Fetch in flight: the new target appears 1 cycle after the killed response.
- **Mid-operation reset:** returns to IDLE immediately, clears kill and the buffer. A later response for the pre-reset request is ignored because it arrives in IDLE or REQ.

## Test plan
- **Reset and sequential fetch:** release reset, ready=1, 1-cycle response latency. Expect:
  - addrs 0x30000000, 0x30000004, 0x30000008.
  - if_wen in every second cycle with the matching if_pc and if_inst.
- **Stall into HOLD:** stall=1 when the response for 0x30000004 (inst 0x00100093) arrives. Expect:
  - if_wen=0 for 3 stalled cycles.
  - On stall release, if_wen=1 with pc 0x30000004 and inst 0x00100093.
  - Next request addr 0x30000008.
- **Redirect with fetch outstanding:** redirect_valid with target 0x30000100 while in WAIT. Expect:
  - if_flush=1 that cycle.
  - The late response is dropped with no if_wen.
  - Next req addr 0x30000100.
- **Simultaneous redirect and response:** redirect to 0x80000000 in the same cycle as imem_rsp_valid. Expect:
  - if_wen=0 and if_flush=1.
  - Next cycle req addr 0x80000000.
- **Double redirect, unaccepted request, wrap:**
  - ready=0 in REQ with redirect to 0x40 then to 0x80: addr is held until accepted, its response is discarded, next addr is 0x80.
  - Separately, redirect to 0xFFFFFFFC: the next sequential addr is 0x00000000.
- **Async reset mid-WAIT:** assert reset asynchronously mid-WAIT. Expect:
  - Outputs go to 0 immediately.
  - The stale response is ignored.
  - Fetch restarts at 0x30000000.
